// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the pooling FSM state encoding.
package cnn_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned FMAP_W_DEF = 4;
   localparam int unsigned FMAP_H_DEF = 4;
   localparam int unsigned IDX_W      = 16;

   typedef enum logic [1:0] {
      ST_TOP  = 2'd0,
      ST_BOT  = 2'd1,
      ST_SKIP = 2'd2
   } pool_state_t;

endpackage

// File: rtl/max2.sv
// Unsigned maximum of two values; ties return the shared value.
module max2 #(
   parameter int unsigned W = cnn_pkg::DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] max_c
);

   assign max_c = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_stream_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order feature map.
// Top-row pair maxima are parked in a line buffer until the bottom row arrives.
module maxpool_stream_2x2 #(
   parameter int unsigned FMAP_W = cnn_pkg::FMAP_W_DEF,
   parameter int unsigned FMAP_H = cnn_pkg::FMAP_H_DEF,
   parameter int unsigned DATA_W = cnn_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic [15:0]       out_row,
   output logic [15:0]       out_col,
   output logic              frame_done
);
   import cnn_pkg::*;

   localparam int unsigned COL_W         = $clog2(FMAP_W);
   localparam int unsigned ROW_W         = $clog2(FMAP_H);
   localparam int unsigned LB_N          = FMAP_W / 2;
   localparam int unsigned LB_AW         = (LB_N > 1) ? $clog2(LB_N) : 1;
   localparam int unsigned LAST_COL_USED = 2 * (FMAP_W / 2) - 1;
   localparam int unsigned LAST_ROW_USED = 2 * (FMAP_H / 2) - 1;
   localparam bit          H_ODD         = (FMAP_H % 2) == 1;

   pool_state_t       state;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [DATA_W-1:0] pair;
   logic [DATA_W-1:0] linebuf [LB_N];

   logic              last_col;
   logic              last_row;
   logic              in_window;
   logic [LB_AW-1:0]  lb_idx;
   logic [DATA_W-1:0] lb_rd;
   logic [DATA_W-1:0] h_max;
   logic [DATA_W-1:0] v_max;

   assign last_col  = (col == COL_W'(FMAP_W - 1));
   assign last_row  = (row == ROW_W'(FMAP_H - 1));
   // Trailing column of an odd-width map never forms a full window.
   assign in_window = (col <= COL_W'(LAST_COL_USED));
   assign lb_idx    = LB_AW'(col >> 1);
   assign lb_rd     = linebuf[lb_idx];

   max2 #(.W(DATA_W)) u_max_h (
      .a     (pair),
      .b     (in_data),
      .max_c (h_max)
   );

   max2 #(.W(DATA_W)) u_max_v (
      .a     (lb_rd),
      .b     (h_max),
      .max_c (v_max)
   );

   // Line buffer: every entry is rewritten in TOP before BOT reads it, so no reset.
   always_ff @(posedge clk) begin
      if (!reset && in_valid && state == ST_TOP && in_window && col[0]) begin
         linebuf[lb_idx] <= h_max;
      end
   end

   // Raster counters, row-phase FSM and registered pooled outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_TOP;
         col        <= '0;
         row        <= '0;
         pair       <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (in_valid) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) begin
               row <= last_row ? '0 : row + 1'b1;
            end

            if (state != ST_SKIP && in_window && !col[0]) begin
               pair <= in_data;
            end

            if (state == ST_BOT && in_window && col[0]) begin
               out_data   <= v_max;
               out_valid  <= 1'b1;
               out_row    <= 16'(row >> 1);
               out_col    <= 16'(col >> 1);
               frame_done <= (row == ROW_W'(LAST_ROW_USED)) &&
                             (col == COL_W'(LAST_COL_USED));
            end

            case (state)
               ST_TOP: begin
                  if (last_col) state <= ST_BOT;
               end
               ST_BOT: begin
                  if (last_col) begin
                     if (H_ODD && row == ROW_W'(FMAP_H - 2)) state <= ST_SKIP;
                     else                                   state <= ST_TOP;
                  end
               end
               ST_SKIP: begin
                  if (last_col && last_row) state <= ST_TOP;
               end
               default: state <= ST_TOP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_maxpool_stream_2x2.sv
// Scoreboard bench for maxpool_stream_2x2: a 4x4 instance and a 3x3 instance.
module tb_maxpool_stream_2x2;

   typedef struct {
      logic [15:0] d;
      logic [15:0] r;
      logic [15:0] c;
      logic        fd;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [15:0] a_in, b_in;
   logic        a_iv, b_iv;
   logic [15:0] a_od, b_od, a_or, b_or, a_oc, b_oc;
   logic        a_ov, b_ov, a_fd, b_fd;

   exp_t qa[$];
   exp_t qb[$];
   exp_t a_last, b_last, e;

   logic [15:0] ramp  [16];
   logic [15:0] ones  [16];
   logic [15:0] zeros [16];
   logic [15:0] ex_ramp  [4];
   logic [15:0] ex_ones  [4];
   logic [15:0] ex_zeros [4];

   maxpool_stream_2x2 #(.FMAP_W(4), .FMAP_H(4), .DATA_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .in_data(a_in), .in_valid(a_iv),
      .out_data(a_od), .out_valid(a_ov), .out_row(a_or), .out_col(a_oc),
      .frame_done(a_fd)
   );

   maxpool_stream_2x2 #(.FMAP_W(3), .FMAP_H(3), .DATA_W(16)) u_dut_b (
      .clk(clk), .reset(reset), .in_data(b_in), .in_valid(b_iv),
      .out_data(b_od), .out_valid(b_ov), .out_row(b_or), .out_col(b_oc),
      .frame_done(b_fd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_a(input logic [15:0] d, input logic v);
      @(posedge clk); #1;
      a_in = d; a_iv = v;
   endtask

   task automatic drive_b(input logic [15:0] d, input logic v);
      @(posedge clk); #1;
      b_in = d; b_iv = v;
   endtask

   // Completing pixels of a 4x4 frame are indices 5, 7, 13, 15.
   task automatic frame4(input logic [15:0] px [16], input logic [15:0] ex [4], input bit gap);
      int k;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         drive_a(px[i], 1'b1);
         if (i == 5 || i == 7 || i == 13 || i == 15) begin
            qa.push_back('{d: ex[k], r: 16'(k / 2), c: 16'(k % 2), fd: (k == 3), cyc: cyc + 1});
            k++;
         end
         if (gap) drive_a(16'hDEAD, 1'b0);
      end
   endtask

   // Monitor: DUT A
   always @(negedge clk) begin
      if (reset) begin
         a_last = '{d: 16'h0, r: 16'h0, c: 16'h0, fd: 1'b0, cyc: 0};
      end else if (a_ov) begin
         if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL A unexpected output: got data %0h at (%0d,%0d) expected none", a_od, a_or, a_oc);
         end else begin
            e = qa.pop_front();
            chk("A out_data", 32'(a_od), 32'(e.d));
            chk("A out_row",  32'(a_or), 32'(e.r));
            chk("A out_col",  32'(a_oc), 32'(e.c));
            chk("A frame_done", 32'(a_fd), 32'(e.fd));
            chk("A latency cycle", 32'(cyc), 32'(e.cyc));
            a_last = e;
         end
      end else begin
         chk("A hold out_data", 32'(a_od), 32'(a_last.d));
         chk("A hold out_row",  32'(a_or), 32'(a_last.r));
         chk("A hold out_col",  32'(a_oc), 32'(a_last.c));
         chk("A frame_done without valid", 32'(a_fd), 32'h0);
      end
   end

   // Monitor: DUT B
   always @(negedge clk) begin
      if (reset) begin
         b_last = '{d: 16'h0, r: 16'h0, c: 16'h0, fd: 1'b0, cyc: 0};
      end else if (b_ov) begin
         if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL B unexpected output: got data %0h at (%0d,%0d) expected none", b_od, b_or, b_oc);
         end else begin
            exp_t eb;
            eb = qb.pop_front();
            chk("B out_data", 32'(b_od), 32'(eb.d));
            chk("B out_row",  32'(b_or), 32'(eb.r));
            chk("B out_col",  32'(b_oc), 32'(eb.c));
            chk("B frame_done", 32'(b_fd), 32'(eb.fd));
            chk("B latency cycle", 32'(cyc), 32'(eb.cyc));
            b_last = eb;
         end
      end else begin
         chk("B hold out_data", 32'(b_od), 32'(b_last.d));
         chk("B frame_done without valid", 32'(b_fd), 32'h0);
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ramp[i]  = 16'(i);
         ones[i]  = 16'hFFFF;
         zeros[i] = 16'h0000;
      end
      ex_ramp[0] = 16'd5;  ex_ramp[1] = 16'd7;  ex_ramp[2] = 16'd13; ex_ramp[3] = 16'd15;
      for (int i = 0; i < 4; i++) begin
         ex_ones[i]  = 16'hFFFF;
         ex_zeros[i] = 16'h0000;
      end

      reset = 1'b1;
      a_in = '0; a_iv = 1'b0;
      b_in = '0; b_iv = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("A reset out_valid",  32'(a_ov), 32'h0);
      chk("A reset out_data",   32'(a_od), 32'h0);
      chk("A reset out_row",    32'(a_or), 32'h0);
      chk("A reset out_col",    32'(a_oc), 32'h0);
      chk("A reset frame_done", 32'(a_fd), 32'h0);
      chk("B reset out_valid",  32'(b_ov), 32'h0);

      // Ramp 0..15, continuous valid
      frame4(ramp, ex_ramp, 1'b0);
      repeat (3) drive_a(16'hBEEF, 1'b0);

      // Same frame with a bubble after every pixel
      frame4(ramp, ex_ramp, 1'b1);
      repeat (3) drive_a(16'hBEEF, 1'b0);

      // Partial frame 100..105; pixel 105 completes window (0,0)
      for (int i = 0; i < 6; i++) begin
         drive_a(16'(100 + i), 1'b1);
         if (i == 5) qa.push_back('{d: 16'd105, r: 16'd0, c: 16'd0, fd: 1'b0, cyc: cyc + 1});
      end
      drive_a(16'hBEEF, 1'b0);
      // Reset mid-frame with in_valid held high on a large value
      @(posedge clk); #1;
      reset = 1'b1; a_in = 16'd999; a_iv = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; a_iv = 1'b0;
      frame4(ramp, ex_ramp, 1'b0);

      // Back-to-back frames, second all 0xFFFF
      frame4(ramp, ex_ramp, 1'b0);
      frame4(ones, ex_ones, 1'b0);
      repeat (2) drive_a(16'h1234, 1'b0);

      // All-equal zero frame
      frame4(zeros, ex_zeros, 1'b0);
      repeat (3) drive_a(16'hBEEF, 1'b0);

      // 3x3: pixels 1..9 twice; only window (0,0) = max(1,2,4,5) counts
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 9; i++) begin
            drive_b(16'(i + 1), 1'b1);
            if (i == 4) qb.push_back('{d: 16'd5, r: 16'd0, c: 16'd0, fd: 1'b1, cyc: cyc + 1});
         end
      end
      repeat (5) drive_b(16'hBEEF, 1'b0);

      chk("A scoreboard drained", 32'(qa.size()), 32'h0);
      chk("B scoreboard drained", 32'(qb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/maxpool_stream_2x2.md
MAXPOOL_STREAM_2X2 -- requirements
Module: maxpool_stream_2x2

Interface
REQ-001 Parameter FMAP_W, default 4: feature-map width in pixels (>=2).
REQ-002 Parameter FMAP_H, default 4: feature-map height in pixels (>=2).
REQ-003 Parameter DATA_W, default 16: pixel width; matches the ReLU output width.
REQ-004 Port clk  input  1  the single clock; all logic updates on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  DATA_W  ReLU output pixel, raster order, treated as unsigned.
REQ-007 Port in_valid  input  1  in_data valid this cycle; no backpressure, so every valid pixel shall be accepted.
REQ-008 Port out_data  output  DATA_W  pooled 2x2 maximum.
REQ-009 Port out_valid  output  1  single-cycle strobe qualifying out_data.
REQ-010 Port out_row  output  16  pooled row index of out_data.
REQ-011 Port out_col  output  16  pooled column index of out_data.
REQ-012 Port frame_done  output  1  single-cycle strobe marking the final pooled output of a frame.

Function
REQ-013 The block shall implement 2x2 max pooling with stride 2 over a FMAP_W x FMAP_H stream, producing floor(FMAP_W/2) x floor(FMAP_H/2) outputs per frame.
REQ-014 Column and row counters shall advance only on in_valid; col wraps FMAP_W-1 -> 0 and increments row; row wraps FMAP_H-1 -> 0 at end of frame.
REQ-015 FSM states: TOP (even row), BOT (odd row), SKIP (trailing row when FMAP_H is odd); TOP->BOT and BOT->TOP (or BOT->SKIP) on the last pixel of a row; SKIP->TOP on the last pixel of the frame; BOT->TOP on frame end when FMAP_H is even.
REQ-016 On an even column, the pixel shall be held in a pair register.
REQ-017 In TOP, on an odd column, max(pair, in_data) shall be written to line-buffer entry col/2.
REQ-018 In BOT, on an odd column, max(linebuf[col/2], pair, in_data) shall be registered to out_data.
REQ-019 In BOT, out_valid shall pulse the cycle after that odd-column in_valid, giving 1-cycle latency from the bottom-right window pixel.
REQ-020 When FMAP_W is odd, column FMAP_W-1 shall be counted but shall not affect any output.
REQ-021 In SKIP, pixels shall be counted only; no buffer writes and no outputs.
REQ-022 frame_done shall assert in the same cycle as out_valid for pooled position (floor(FMAP_H/2)-1, floor(FMAP_W/2)-1).
REQ-023 out_data, out_row, and out_col shall hold their last values when out_valid is low.
REQ-024 Comparisons shall be unsigned, and ties shall yield the equal value; no width growth occurs.
REQ-025 Gaps in in_valid shall not alter results; the state shall freeze while in_valid is low.
REQ-026 A new frame shall begin immediately after the last pixel with no idle cycle required, so back-to-back frames are supported.

Reset
REQ-027 When reset is high at a clock edge, the state shall become TOP, and col, row, pair, out_data, out_row, out_col, out_valid, and frame_done shall all become 0.
REQ-028 Line-buffer contents shall not require reset, since every entry is rewritten in TOP before it is read.
REQ-029 Reset asserted mid-frame shall abandon the partial frame, and the next valid pixel after reset deasserts shall be treated as pixel (0,0).
REQ-030 Reset shall take priority over a simultaneous in_valid.

Structure
REQ-031 A shared package (cnn_pkg) shall hold DATA_W, the default FMAP_W and FMAP_H, and the FSM state encoding.
REQ-032 A single combinational sub-module, max2 (unsigned max of two DATA_W values), shall be instantiated for the pair and vertical compares.
REQ-033 The line buffer shall be a register array of floor(FMAP_W/2) entries of DATA_W bits.

Verification
REQ-034 4x4 frame, pixels 0..15, continuous valid -> outputs 5, 7, 13, 15 at (0,0), (0,1), (1,0), (1,1); frame_done coincides with 15.
REQ-035 Same 4x4 frame with in_valid low every other cycle -> identical outputs and indices; each out_valid follows its completing pixel by 1 cycle.
REQ-036 FMAP_W = FMAP_H = 3, pixels 1..9 -> exactly one output, 5, with frame_done; pixels 3, 6, 7, 8, 9 have no effect.
REQ-037 4x4 frame with reset asserted after 6 pixels, then a full frame of 0..15 -> outputs exactly 5, 7, 13, 15 with no stale output.
REQ-038 Two back-to-back 4x4 frames, the second all 0xFFFF -> 5, 7, 13, 15 then four outputs of 0xFFFF; frame_done pulses twice.
REQ-039 4x4 frame of all-equal 0x0000 -> four outputs of 0x0000; out_valid is never missed on ties.
